// File: rtl/sap_cu_gen2.sv
// rtl/sap_cu_gen2.sv - multi-cycle control unit for the 16-bit SAP core
module sap_cu_gen2 #(
  parameter int OPW    = 8,
  parameter int ALUOPW = 4,
  parameter int NFLAG  = 3,
  parameter int VECW   = 16,
  parameter logic [VECW-1:0] IRQ_VEC = 16'h00F0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OPW-1:0]       opcode,
  input  logic [NFLAG-1:0]     flags,
  input  logic                 irq,
  input  logic                 step_en,
  input  logic                 step,
  input  logic                 resume,
  output logic [12+ALUOPW-1:0] cs,
  output logic [6:0]           bus_cs,
  output logic [VECW-1:0]      vec_data,
  output logic                 irq_ack,
  output logic                 halted,
  output logic                 illegal_op,
  output logic [4:0]           state_dbg
);

  typedef enum logic [4:0] {
    S_IDLE, S_F1, S_F2, S_LDA1, S_LDA2, S_STA1, S_STA2, S_ALU1, S_ALU2, S_ALU3,
    S_JMP1, S_LDI1, S_OUT1, S_CALL1, S_CALL2, S_CALL3, S_RET1, S_RET2, S_RET3,
    S_INT1, S_INT2, S_INT3, S_STEPW, S_HLT
  } state_t;

  state_t state;
  logic   ie;

  logic [5:0] op;
  logic       upper_nz;
  logic       illegal;
  logic       unary;
  state_t     boundary;

  assign op = opcode[5:0];

  generate
    if (OPW > 6) begin : g_upper
      assign upper_nz = |opcode[OPW-1:6];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

  assign illegal  = upper_nz || (op > 6'h17);
  assign unary    = (op == 6'h05) || (op == 6'h06) || (op == 6'h0A);
  assign boundary = (irq && ie) ? S_INT1 : (step_en ? S_STEPW : S_F1);

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      ie    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_F1;
        S_F1:   state <= S_F2;
        S_F2: begin
          if (illegal) begin
            state <= boundary;
          end else begin
            if (op == 6'h15) ie <= 1'b1;
            if (op == 6'h16) ie <= 1'b0;
            case (op)
              6'h01: state <= S_LDA1;
              6'h02: state <= S_STA1;
              6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A: state <= S_ALU1;
              6'h0B: state <= S_JMP1;
              6'h0C: state <= flags[0]  ? S_JMP1 : boundary;
              6'h0D: state <= flags[1]  ? S_JMP1 : boundary;
              6'h11: state <= flags[2]  ? S_JMP1 : boundary;
              6'h12: state <= !flags[0] ? S_JMP1 : boundary;
              6'h0E: state <= S_LDI1;
              6'h0F: state <= S_OUT1;
              6'h10: state <= S_HLT;
              6'h13: state <= S_CALL1;
              6'h14, 6'h17: state <= S_RET1;
              default: state <= boundary;
            endcase
          end
        end
        S_LDA1:  state <= S_LDA2;
        S_STA1:  state <= S_STA2;
        S_ALU1:  state <= unary ? boundary : S_ALU2;
        S_ALU2:  state <= S_ALU3;
        S_CALL1: state <= S_CALL2;
        S_CALL2: state <= S_CALL3;
        S_RET1:  state <= S_RET2;
        S_RET2:  state <= S_RET3;
        S_RET3: begin
          if (op == 6'h17) ie <= 1'b1;
          state <= boundary;
        end
        S_INT1: state <= S_INT2;
        S_INT2: state <= S_INT3;
        // ie drops on this edge, so a still-pending irq must not re-enter here
        S_INT3: begin
          ie    <= 1'b0;
          state <= step_en ? S_STEPW : S_F1;
        end
        S_STEPW: if (step) state <= S_F1;
        S_HLT: begin
          if (irq && ie)  state <= S_INT1;
          else if (resume) state <= S_F1;
        end
        default: state <= boundary;
      endcase
    end
  end

  logic [ALUOPW-1:0] alu_code;
  always_comb begin
    alu_code = '0;
    case (op)
      6'h03: alu_code = ALUOPW'(1);
      6'h04: alu_code = ALUOPW'(2);
      6'h05: alu_code = ALUOPW'(3);
      6'h06: alu_code = ALUOPW'(4);
      6'h07: alu_code = ALUOPW'(5);
      6'h08: alu_code = ALUOPW'(6);
      6'h09: alu_code = ALUOPW'(7);
      6'h0A: alu_code = ALUOPW'(8);
      default: alu_code = '0;
    endcase
  end

  logic acc_write, acc_lower_write, b_write, flag_write, ir_write, mar_write;
  logic out_write, pc_inc, pc_write, ram_write, sp_inc, sp_dec;
  logic acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus, sp_to_bus, vec_to_bus;
  logic [ALUOPW-1:0] alu_op;

  always_comb begin
    {acc_write, acc_lower_write, b_write, flag_write, ir_write, mar_write} = '0;
    {out_write, pc_inc, pc_write, ram_write, sp_inc, sp_dec} = '0;
    {acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus, sp_to_bus, vec_to_bus} = '0;
    alu_op = '0;
    case (state)
      S_F1:   begin pc_to_bus = 1'b1; mar_write = 1'b1; end
      S_F2:   begin ram_to_bus = 1'b1; ir_write = 1'b1; pc_inc = 1'b1; end
      S_LDA1, S_STA1: begin ir_to_bus = 1'b1; mar_write = 1'b1; end
      S_LDA2: begin ram_to_bus = 1'b1; acc_write = 1'b1; end
      S_STA2: begin acc_to_bus = 1'b1; ram_write = 1'b1; end
      S_ALU1: begin
        if (unary) begin
          alu_op = alu_code; alu_to_bus = 1'b1; acc_write = 1'b1; flag_write = 1'b1;
        end else begin
          ir_to_bus = 1'b1; mar_write = 1'b1;
        end
      end
      S_ALU2: begin ram_to_bus = 1'b1; b_write = 1'b1; end
      S_ALU3: begin alu_op = alu_code; alu_to_bus = 1'b1; acc_write = 1'b1; flag_write = 1'b1; end
      S_JMP1, S_CALL3: begin ir_to_bus = 1'b1; pc_write = 1'b1; end
      S_LDI1: begin ir_to_bus = 1'b1; acc_lower_write = 1'b1; end
      S_OUT1: begin acc_to_bus = 1'b1; out_write = 1'b1; end
      S_CALL1, S_RET2, S_INT1: begin sp_to_bus = 1'b1; mar_write = 1'b1; end
      S_CALL2, S_INT2: begin pc_to_bus = 1'b1; ram_write = 1'b1; sp_dec = 1'b1; end
      S_RET1: sp_inc = 1'b1;
      S_RET3: begin ram_to_bus = 1'b1; pc_write = 1'b1; end
      S_INT3: begin vec_to_bus = 1'b1; pc_write = 1'b1; end
      default: ;
    endcase
  end

  assign cs = {acc_write, acc_lower_write, alu_op, b_write, flag_write, ir_write,
               mar_write, out_write, pc_inc, pc_write, ram_write, sp_inc, sp_dec};
  assign bus_cs = {acc_to_bus, alu_to_bus, ir_to_bus, pc_to_bus, ram_to_bus,
                   sp_to_bus, vec_to_bus};
  assign vec_data   = IRQ_VEC;
  assign irq_ack    = (state == S_INT1);
  assign halted     = (state == S_HLT);
  assign illegal_op = (state == S_F2) && illegal;
  assign state_dbg  = state;

endmodule
